eprisc_rom_fetch: RTL
=====================

Name: eprisc_rom_fetch

Overview:
- Instruction fetch stage directly upstream of the epRISC embedded boot ROM (8-bit address, 32-bit data, one-cycle registered read, tri-stated output gated by enable).
- Holds the fetch PC, issues one ROM read per cycle, and captures the returned words into a 2-entry instruction buffer.
- Presents instructions to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with flush of buffered and in-flight words.

Parameters:
- ADDR_W, 8, ROM address width; the PC wraps modulo 2^ADDR_W.
- DATA_W, 32, instruction width.
- RESET_ADDR, 0, PC value after reset.

Ports:
- iClk  input  1  clock; all state changes on rising edge.
- iReset  input  1  asynchronous, active-low reset.
- iRun  input  1  fetch enable; 0 = issue no new reads.
- oRomAddr  output  ADDR_W  ROM address; equals the PC register.
- oRomEnable  output  1  ROM output enable; high only in the cycle after an issued read.
- iRomData  input  DATA_W  ROM data bus; valid while oRomEnable=1.
- oInstr  output  DATA_W  buffer head instruction.
- oInstrPC  output  ADDR_W  address the head instruction was fetched from.
- oValid  output  1  buffer non-empty.
- iReady  input  1  decode accepts head this cycle.
- iRedirect  input  1  flush and restart fetch.
- iRedirectAddr  input  ADDR_W  new fetch address when iRedirect=1.

Behaviour:
- Reset (async assert, sync-style deassert handled externally):
  - PC=RESET_ADDR, so oRomAddr=RESET_ADDR.
  - pending=0, oRomEnable=0.
  - Buffer count=0, so oValid=0.
  - oInstr=0, oInstrPC=0.
  - Reset mid-operation discards all buffered and in-flight words.
- State: PC, pending flag plus pending address, 2-entry FIFO of {instr, pc} (head/tail pointers, count 0..2).
- pop = oValid & iReady & ~iRedirect.
- Issue condition: iRun & ~iRedirect & (count + pending - pop < 2).
- On issue, at the rising edge:
  - ROM samples oRomAddr.
  - PC <= PC+1 (255 wraps to 0).
  - pending <= 1, pending address <= PC.
- Without issue: pending <= 0, PC holds.
- Capture: oRomEnable = pending (registered, glitch-free). At the edge ending a cycle with pending=1, {iRomData, pending address} is written at the tail.
- Latency:
  - Request in cycle C, oRomEnable=1 in C+1, oValid=1 in C+2.
  - Reset release with iRun=1: first instruction (RESET_ADDR) visible 2 cycles after the first active edge.
- Throughput: 1 instruction/cycle sustained while iReady=1 (steady state count=1, pending=1).
- Simultaneous capture and pop: count is unchanged and the head advances. The capture-into-full case cannot occur, guaranteed by the issue condition; an assertion flags count overflow.
- iReady=0 with a full buffer: no issue, PC holds, oInstr/oInstrPC stable.
- iRun=0:
  - An in-flight read still completes and is captured.
  - No new reads are issued.
  - The buffer drains normally.
- Redirect has priority over everything:
  - At the edge: count <= 0, pending <= 0, PC <= iRedirectAddr.
  - Any handshake in that cycle is void (no pop).
  - ROM data returning in that cycle is discarded, though oRomEnable still follows pending.
  - The first fetch at the new address issues the cycle after the redirect (if iRun=1), so oValid returns 2 cycles after that.
  - A redirect while oValid=0 or the buffer is empty behaves identically.
- Back-to-back redirects: the last one wins; each flushes.

Test Plan:
- Reset release, iRun=1, iReady=1, ROM preloaded with word[n]=32'h1000_0000+n:
  - oRomEnable=0 and oValid=0 through reset.
  - oValid rises cycle 2.
  - oInstr sequence 1000_0000, 1000_0001, ... on consecutive cycles with oInstrPC 0,1,2.
- Backpressure: iReady=0 from cycle 3 for 5 cycles:
  - count saturates at 2 and PC stops advancing.
  - oInstr holds.
  - On iReady=1 the instructions resume in order with none lost or duplicated.
- Redirect while full, iRedirectAddr=8'h40:
  - The next cycle shows oValid=0 and oRomAddr=40.
  - oValid returns 2 cycles later with oInstrPC=40, and no stale word ever appears.
- Redirect with an in-flight read (pending=1): the returned word is not enqueued, checked by scoreboard.
- PC wrap: redirect to 8'hFE with continuous accept → oInstrPC FE, FF, 00, 01.
- iRun dropped for 1 cycle mid-stream:
  - The in-flight word is still delivered.
  - Exactly one bubble follows.
  - The sequence continues without a gap in oInstrPC.

Source files
------------

// File: rtl/eprisc_rom_fetch_if.sv
// Fetch-stage bus bundle: ROM request/response side plus the decode handshake.
// master = fetch stage, slave = ROM model / decode consumer.
interface eprisc_rom_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              iRun;
  logic [ADDR_W-1:0] oRomAddr;
  logic              oRomEnable;
  logic [DATA_W-1:0] iRomData;
  logic [DATA_W-1:0] oInstr;
  logic [ADDR_W-1:0] oInstrPC;
  logic              oValid;
  logic              iReady;
  logic              iRedirect;
  logic [ADDR_W-1:0] iRedirectAddr;

  modport master (
    input  iRun, iRomData, iReady, iRedirect, iRedirectAddr,
    output oRomAddr, oRomEnable, oInstr, oInstrPC, oValid
  );

  modport slave (
    output iRun, iRomData, iReady, iRedirect, iRedirectAddr,
    input  oRomAddr, oRomEnable, oInstr, oInstrPC, oValid
  );
endinterface

// File: rtl/eprisc_rom_fetch.sv
// epRISC instruction fetch: PC, one ROM read per cycle, 2-entry {instr, pc}
// buffer toward decode, redirect flushes buffered and in-flight words.
module eprisc_rom_fetch #(
  parameter int              ADDR_W     = 8,
  parameter int              DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input logic                iClk,
  input logic                iReset,
  eprisc_rom_fetch_if.master bus
);

  logic [ADDR_W-1:0]            pc_q, pc_d;
  logic                         pend_q, pend_d;
  logic [ADDR_W-1:0]            pend_addr_q, pend_addr_d;
  logic [1:0][DATA_W-1:0]       instr_q, instr_d;
  logic [1:0][ADDR_W-1:0]       ipc_q, ipc_d;
  logic                         head_q, head_d;
  logic                         tail_q, tail_d;
  logic [1:0]                   cnt_q, cnt_d;

  logic       valid;
  logic       pop;
  logic       cap;
  logic       issue;
  logic [2:0] occ;

  assign valid = (cnt_q != 2'd0);
  // A redirect voids any handshake in the same cycle.
  assign pop   = valid & bus.iReady & ~bus.iRedirect;
  // Returning word is dropped if a redirect lands on the same edge.
  assign cap   = pend_q & ~bus.iRedirect;
  // Occupancy after this edge counting the in-flight read; keeps the buffer from overflowing.
  assign occ   = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, pop};
  assign issue = bus.iRun & ~bus.iRedirect & (occ < 3'd2);

  assign bus.oRomAddr   = pc_q;
  assign bus.oRomEnable = pend_q;
  assign bus.oInstr     = instr_q[head_q];
  assign bus.oInstrPC   = ipc_q[head_q];
  assign bus.oValid     = valid;

  // Next-state: redirect flushes everything, otherwise issue/capture/pop.
  always_comb begin
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    if (bus.iRedirect) begin
      pc_d   = bus.iRedirectAddr;
      pend_d = 1'b0;
      cnt_d  = 2'd0;
      head_d = 1'b0;
      tail_d = 1'b0;
    end else begin
      pend_d = issue;
      if (issue) begin
        pc_d        = pc_q + 1'b1;
        pend_addr_d = pc_q;
      end
      if (cap) begin
        instr_d[tail_q] = bus.iRomData;
        ipc_d[tail_q]   = pend_addr_q;
        tail_d          = ~tail_q;
      end
      if (pop) head_d = ~head_q;
      cnt_d = cnt_q + {1'b0, cap} - {1'b0, pop};
    end
  end

  // State registers, cleared asynchronously so in-flight work is discarded.
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      pc_q        <= RESET_ADDR;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      instr_q     <= '0;
      ipc_q       <= '0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      instr_q     <= instr_d;
      ipc_q       <= ipc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
    end
  end

  // Capture into a full buffer must never happen; the issue gate prevents it.
  always_ff @(posedge iClk) begin
    if (iReset) assert (!(cap && !pop && cnt_q == 2'd2));
  end

endmodule
